// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the 4-stage pipeline hazard/forwarding controller:
// forwarding-select codes and FSM state encodings.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// 'state' is a read-only debug view of the controller FSM.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memacc;
  logic              flush;
  logic              dmem_ready;
  logic [1:0]        rs1_hazard;
  logic [1:0]        rs2_hazard;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        state;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, flush, dmem_ready,
    input  rs1_hazard, rs2_hazard, stall_if, stall_id, bubble_ex, stall_cnt, state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, flush, dmem_ready,
    output rs1_hazard, rs2_hazard, stall_if, stall_id, bubble_ex, stall_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding-select comparator for one source operand. EX beats WB; x0 and
// loads still in EX are never forwarded from EX.
module fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_ex_v,
  input  logic              i_ex_wr,
  input  logic              i_ex_ld,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_wb_v,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  output logic [1:0]        o_sel
);

  logic w_src_nz;
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_src_nz = |i_src;
  assign w_ex_hit = i_use & i_ex_v & i_ex_wr & ~i_ex_ld & (i_ex_rd == i_src) & w_src_nz;
  assign w_wb_hit = i_use & i_wb_v & i_wb_wr & (i_wb_rd == i_src) & w_src_nz;

  // NOTE: assign a default first in every always_comb so no path leaves o_sel unassigned (latch).
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)      o_sel = FWD_EX;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: tracks EX/WB destinations, drives forward
// selects, inserts load-use bubbles, freezes on data-memory wait, counts stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  logic              r_ex_v, r_ex_wr, r_ex_ld, r_ex_ma;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_wb_v, r_wb_wr, r_wb_ma;
  logic [REG_AW-1:0] r_wb_rd;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_load_use;
  logic w_mem_wait;
  logic w_stall;
  logic w_bubble;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .i_use   (bus.id_use_rs1),
    .i_src   (bus.id_rs1),
    .i_ex_v  (r_ex_v),
    .i_ex_wr (r_ex_wr),
    .i_ex_ld (r_ex_ld),
    .i_ex_rd (r_ex_rd),
    .i_wb_v  (r_wb_v),
    .i_wb_wr (r_wb_wr),
    .i_wb_rd (r_wb_rd),
    .o_sel   (bus.rs1_hazard)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .i_use   (bus.id_use_rs2),
    .i_src   (bus.id_rs2),
    .i_ex_v  (r_ex_v),
    .i_ex_wr (r_ex_wr),
    .i_ex_ld (r_ex_ld),
    .i_ex_rd (r_ex_rd),
    .i_wb_v  (r_wb_v),
    .i_wb_wr (r_wb_wr),
    .i_wb_rd (r_wb_rd),
    .o_sel   (bus.rs2_hazard)
  );

  assign w_load_use = bus.id_valid & r_ex_v & r_ex_ld & (|r_ex_rd) &
                      ((bus.id_use_rs1 & (r_ex_rd == bus.id_rs1)) |
                       (bus.id_use_rs2 & (r_ex_rd == bus.id_rs2)));
  assign w_mem_wait = r_wb_v & r_wb_ma & ~bus.dmem_ready;

  // A memory freeze overrides everything; a taken branch cancels a load-use stall.
  assign w_stall  = w_mem_wait | (w_load_use & ~bus.flush);
  assign w_bubble = ~w_mem_wait & (w_load_use | bus.flush | ~bus.id_valid);

  assign bus.stall_if  = w_stall;
  assign bus.stall_id  = w_stall;
  assign bus.bubble_ex = w_bubble;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.state     = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait)                    w_state_nxt = ST_MEMWAIT;
        else if (w_load_use && !bus.flush) w_state_nxt = ST_LDSTALL;
      end
      ST_LDSTALL: w_state_nxt = w_mem_wait ? ST_MEMWAIT : ST_RUN;
      ST_MEMWAIT: if (bus.dmem_ready) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values (wb <= ex relies on this).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_ex_v      <= 1'b0;
      r_ex_wr     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_ma     <= 1'b0;
      r_ex_rd     <= '0;
      r_wb_v      <= 1'b0;
      r_wb_wr     <= 1'b0;
      r_wb_ma     <= 1'b0;
      r_wb_rd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_mem_wait) begin
        r_wb_v  <= r_ex_v;
        r_wb_wr <= r_ex_wr;
        r_wb_ma <= r_ex_ma;
        r_wb_rd <= r_ex_rd;
        if (w_bubble) begin
          r_ex_v  <= 1'b0;
          r_ex_wr <= 1'b0;
          r_ex_ld <= 1'b0;
          r_ex_ma <= 1'b0;
          r_ex_rd <= '0;
        end else begin
          r_ex_v  <= 1'b1;
          r_ex_wr <= bus.id_regwrite;
          r_ex_ld <= bus.id_memread;
          r_ex_ma <= bus.id_memacc;
          r_ex_rd <= bus.id_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each driven cycle pushes its
// hand-derived expected outputs; the falling-edge monitor pops and compares.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct {
    int         step;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       stall;
    logic       bub;
    logic [31:0] cnt;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          step_no = 0;
  logic [31:0] m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("s%0d_rs1_hazard", e.step), 32'(bus.rs1_hazard), 32'(e.rs1));
      check($sformatf("s%0d_rs2_hazard", e.step), 32'(bus.rs2_hazard), 32'(e.rs2));
      check($sformatf("s%0d_stall_if",   e.step), 32'(bus.stall_if),   32'(e.stall));
      check($sformatf("s%0d_stall_id",   e.step), 32'(bus.stall_id),   32'(e.stall));
      check($sformatf("s%0d_bubble_ex",  e.step), 32'(bus.bubble_ex),  32'(e.bub));
      check($sformatf("s%0d_stall_cnt",  e.step), bus.stall_cnt,       e.cnt);
      check($sformatf("s%0d_state",      e.step), 32'(bus.state),      32'(e.st));
    end
  end

  task automatic set_id(input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic ma);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_use_rs1  = u1;
    bus.id_rs2      = rs2;
    bus.id_use_rs2  = u2;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_memacc   = ma;
  endtask

  // Push the expected outputs for the cycle just driven, then advance one clock.
  task automatic cyc(input logic [1:0] rs1, input logic [1:0] rs2,
                     input logic stall, input logic bub, input logic [1:0] st);
    exp_t e;
    e.step  = step_no;
    e.rs1   = rs1;
    e.rs2   = rs2;
    e.stall = stall;
    e.bub   = bub;
    e.cnt   = m_cnt;
    e.st    = st;
    sb.push_back(e);
    if (rst)        m_cnt = 0;
    else if (stall) m_cnt = m_cnt + 1;
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.flush      = 1'b0;
    bus.dmem_ready = 1'b1;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(FWD_RF, FWD_RF, 1'b0, 1'b0, ST_RUN);
    rst = 1'b0;

    // Forwarding: add x5 in EX, then x5 in both EX and WB, then WB-only hit.
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd5, 1, 5'd6, 1, 5'd5, 1, 0, 0); cyc(FWD_EX, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd1, 1, 5'd5, 1, 5'd8, 1, 0, 0); cyc(FWD_RF, FWD_EX, 0, 0, ST_RUN);
    set_id(1, 5'd5, 1, 5'd8, 1, 5'd0, 0, 0, 0); cyc(FWD_WB, FWD_EX, 0, 0, ST_RUN);

    // Load-use: lw x7, then a consumer of x7 stalls one cycle and gets WB forward.
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 1); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd7, 1, 5'd3, 1, 5'd9, 1, 0, 0); cyc(FWD_RF, FWD_RF, 1, 1, ST_RUN);
    cyc(FWD_WB, FWD_RF, 0, 0, ST_LDSTALL);

    // x0: a writer and a load of x0 never forward or stall.
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd0, 1, 0, 0); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 1, 1); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 1); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);

    // Store in WB waits three cycles for memory: frozen, tracking held.
    set_id(1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 0, 0);
    bus.dmem_ready = 1'b0;
    cyc(FWD_EX, FWD_RF, 1, 0, ST_RUN);
    cyc(FWD_EX, FWD_RF, 1, 0, ST_MEMWAIT);
    cyc(FWD_EX, FWD_RF, 1, 0, ST_MEMWAIT);
    bus.dmem_ready = 1'b1;
    cyc(FWD_EX, FWD_RF, 0, 0, ST_MEMWAIT);

    // Flush coincident with load-use: no stall, bubble only.
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 1); cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);
    set_id(1, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, 0);
    bus.flush = 1'b1;
    cyc(FWD_RF, FWD_RF, 0, 1, ST_RUN);
    bus.flush = 1'b0;

    // Reset in the middle of a memory wait.
    set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    bus.dmem_ready = 1'b0;
    cyc(FWD_RF, FWD_RF, 1, 0, ST_RUN);
    rst = 1'b1;
    cyc(FWD_RF, FWD_RF, 1, 0, ST_MEMWAIT);
    rst = 1'b0;
    cyc(FWD_RF, FWD_RF, 0, 0, ST_RUN);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
